// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory initiator: turns EX/MEM load/store controls into a
// req/ack transaction, returns aligned/extended load data and stalls the pipe.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   EXMEMMemRead/Write/Size/Signed, EXMEMALUResult, EXMEMWriteData
//                                 load/store controls from EX/MEM
//   DMemReq/We/Addr/WData/Be      registered request to data memory
//   DMemAck, DMemRData            one-cycle completion and read word
//   MemoryData                    registered load result to MEM/WB
//   MemStall, MisalignExc, BusErr pipeline freeze and exception flags
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        EXMEMMemRead,
    input  logic        EXMEMMemWrite,
    input  logic [1:0]  EXMEMMemSize,
    input  logic        EXMEMMemSigned,
    input  logic [31:0] EXMEMALUResult,
    input  logic [31:0] EXMEMWriteData,
    output logic        DMemReq,
    output logic        DMemWe,
    output logic [31:0] DMemAddr,
    output logic [31:0] DMemWData,
    output logic [3:0]  DMemBe,
    input  logic        DMemAck,
    input  logic [31:0] DMemRData,
    output logic [31:0] MemoryData,
    output logic        MemStall,
    output logic        MisalignExc,
    output logic        BusErr
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [7:0] TLIM = 8'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [7:0]  cnt;
    logic [1:0]  lane_q;
    logic [1:0]  size_q;
    logic        sgn_q;
    logic        issue;
    logic        timeout;

    logic        acc;
    logic        is_byte;
    logic        is_half;
    logic        is_word;
    logic        misalign;
    logic [1:0]  lane;
    logic [3:0]  be_nxt;
    logic [31:0] wdata_nxt;
    logic [31:0] shifted;
    logic [31:0] ext;

    assign acc      = EXMEMMemRead | EXMEMMemWrite;
    assign lane     = EXMEMALUResult[1:0];
    assign is_byte  = (EXMEMMemSize == 2'b10);
    assign is_half  = (EXMEMMemSize == 2'b01);
    assign is_word  = !is_byte && !is_half;
    assign misalign = (is_half && lane[0]) || (is_word && (lane != 2'b00));
    assign timeout  = (cnt == TLIM);

    // Stores are lane-replicated so memory only needs the byte enables;
    // loads always fetch the full word and extract locally.
    always_comb begin
        be_nxt    = 4'b1111;
        wdata_nxt = EXMEMWriteData;
        if (EXMEMMemWrite) begin
            if (is_byte) begin
                be_nxt    = 4'b0001 << lane;
                wdata_nxt = {4{EXMEMWriteData[7:0]}};
            end else if (is_half) begin
                be_nxt    = lane[1] ? 4'b1100 : 4'b0011;
                wdata_nxt = {2{EXMEMWriteData[15:0]}};
            end
        end
    end

    always_comb begin
        shifted = DMemRData >> {lane_q, 3'b000};
        case (size_q)
            2'b10:   ext = {{24{sgn_q & shifted[7]}}, shifted[7:0]};
            2'b01:   ext = {{16{sgn_q & shifted[15]}}, shifted[15:0]};
            default: ext = shifted;
        endcase
    end

    always_comb begin
        state_nxt   = state;
        MemStall    = 1'b0;
        MisalignExc = 1'b0;
        issue       = 1'b0;
        case (state)
            IDLE: begin
                if (acc) begin
                    if (misalign) begin
                        MisalignExc = 1'b1;
                    end else begin
                        MemStall  = 1'b1;
                        issue     = 1'b1;
                        state_nxt = BUSY;
                    end
                end
            end
            BUSY: begin
                MemStall = 1'b1;
                if (DMemAck || timeout)
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            lane_q     <= '0;
            size_q     <= '0;
            sgn_q      <= 1'b0;
            DMemReq    <= 1'b0;
            DMemWe     <= 1'b0;
            DMemAddr   <= '0;
            DMemWData  <= '0;
            DMemBe     <= '0;
            MemoryData <= '0;
            BusErr     <= 1'b0;
        end else begin
            state  <= state_nxt;
            BusErr <= 1'b0;
            if (issue) begin
                DMemReq   <= 1'b1;
                DMemWe    <= EXMEMMemWrite;
                DMemAddr  <= {EXMEMALUResult[31:2], 2'b00};
                DMemWData <= wdata_nxt;
                DMemBe    <= be_nxt;
                cnt       <= '0;
                lane_q    <= lane;
                size_q    <= EXMEMMemSize;
                sgn_q     <= EXMEMMemSigned;
            end
            if (state == BUSY) begin
                cnt <= cnt + 8'd1;
                // Ack takes precedence over a coincident timeout.
                if (DMemAck) begin
                    DMemReq <= 1'b0;
                    if (!DMemWe)
                        MemoryData <= ext;
                end else if (timeout) begin
                    DMemReq    <= 1'b0;
                    MemoryData <= '0;
                    BusErr     <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed testbench for mem_access_ctrl.
// Drives one access at a time and checks handshake, data and flags.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        EXMEMMemRead;
    logic        EXMEMMemWrite;
    logic [1:0]  EXMEMMemSize;
    logic        EXMEMMemSigned;
    logic [31:0] EXMEMALUResult;
    logic [31:0] EXMEMWriteData;
    logic        DMemReq;
    logic        DMemWe;
    logic [31:0] DMemAddr;
    logic [31:0] DMemWData;
    logic [3:0]  DMemBe;
    logic        DMemAck;
    logic [31:0] DMemRData;
    logic [31:0] MemoryData;
    logic        MemStall;
    logic        MisalignExc;
    logic        BusErr;

    int vec  = 0;
    int miss = 0;

    // values captured during the first BUSY cycle of an access
    logic        c_req;
    logic        c_we;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic [3:0]  c_be;
    int          c_stalls;

    mem_access_ctrl #(.TIMEOUT(16)) dut (
        .clk(clk),
        .rst(rst),
        .EXMEMMemRead(EXMEMMemRead),
        .EXMEMMemWrite(EXMEMMemWrite),
        .EXMEMMemSize(EXMEMMemSize),
        .EXMEMMemSigned(EXMEMMemSigned),
        .EXMEMALUResult(EXMEMALUResult),
        .EXMEMWriteData(EXMEMWriteData),
        .DMemReq(DMemReq),
        .DMemWe(DMemWe),
        .DMemAddr(DMemAddr),
        .DMemWData(DMemWData),
        .DMemBe(DMemBe),
        .DMemAck(DMemAck),
        .DMemRData(DMemRData),
        .MemoryData(MemoryData),
        .MemStall(MemStall),
        .MisalignExc(MisalignExc),
        .BusErr(BusErr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        EXMEMMemRead   = 1'b0;
        EXMEMMemWrite  = 1'b0;
        EXMEMMemSize   = 2'b00;
        EXMEMMemSigned = 1'b0;
        EXMEMALUResult = '0;
        EXMEMWriteData = '0;
        DMemAck        = 1'b0;
        DMemRData      = '0;
    endtask

    // Runs one access; returns in the DONE cycle, 1 time unit after the edge.
    task automatic access(input logic we, input logic [1:0] size,
                          input logic sgn, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rd,
                          input int waits);
        EXMEMMemRead   = !we;
        EXMEMMemWrite  = we;
        EXMEMMemSize   = size;
        EXMEMMemSigned = sgn;
        EXMEMALUResult = addr;
        EXMEMWriteData = wd;
        c_stalls = 0;
        #1;
        c_stalls += int'(MemStall);
        tick();
        c_req   = DMemReq;
        c_we    = DMemWe;
        c_addr  = DMemAddr;
        c_wdata = DMemWData;
        c_be    = DMemBe;
        for (int i = 0; i < waits; i++) begin
            c_stalls += int'(MemStall);
            tick();
        end
        c_stalls += int'(MemStall);
        DMemAck   = 1'b1;
        DMemRData = rd;
        tick();
        DMemAck       = 1'b0;
        EXMEMMemRead  = 1'b0;
        EXMEMMemWrite = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        vec++;
        if (DMemReq !== 1'b0 || DMemBe !== 4'b0 || DMemAddr !== 32'h0 ||
            DMemWData !== 32'h0 || DMemWe !== 1'b0) begin
            miss++;
            $display("FAIL reset_req req=%b be=%b addr=%h wd=%h we=%b, want all 0",
                     DMemReq, DMemBe, DMemAddr, DMemWData, DMemWe);
        end
        vec++;
        if (MemoryData !== 32'h0 || MemStall !== 1'b0 || BusErr !== 1'b0) begin
            miss++;
            $display("FAIL reset_out md=%h stall=%b buserr=%b, want 0/0/0",
                     MemoryData, MemStall, BusErr);
        end
    endtask

    task automatic test_word_load();
        access(1'b0, 2'b00, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0);
        vec++;
        if (c_stalls !== 2) begin
            miss++;
            $display("FAIL wl_stalls got %0d want 2", c_stalls);
        end
        vec++;
        if (c_req !== 1'b1 || c_we !== 1'b0 || c_be !== 4'b1111 ||
            c_addr !== 32'h100) begin
            miss++;
            $display("FAIL wl_req req=%b we=%b be=%b addr=%h want 1 0 1111 100",
                     c_req, c_we, c_be, c_addr);
        end
        vec++;
        if (MemoryData !== 32'hDEADBEEF || MemStall !== 1'b0 || DMemReq !== 1'b0) begin
            miss++;
            $display("FAIL wl_done md=%h stall=%b req=%b want deadbeef 0 0",
                     MemoryData, MemStall, DMemReq);
        end
        tick();
        vec++;
        if (MemStall !== 1'b0 || MemoryData !== 32'hDEADBEEF) begin
            miss++;
            $display("FAIL wl_idle stall=%b md=%h want 0 deadbeef",
                     MemStall, MemoryData);
        end
    endtask

    task automatic test_subword_load();
        access(1'b0, 2'b10, 1'b1, 32'h103, 32'h0, 32'h80FF0011, 0);
        vec++;
        if (MemoryData !== 32'hFFFFFF80 || c_be !== 4'b1111 || c_addr !== 32'h100) begin
            miss++;
            $display("FAIL lb_signed md=%h be=%b addr=%h want ffffff80 1111 100",
                     MemoryData, c_be, c_addr);
        end
        tick();
        access(1'b0, 2'b10, 1'b0, 32'h103, 32'h0, 32'h80FF0011, 0);
        vec++;
        if (MemoryData !== 32'h00000080) begin
            miss++;
            $display("FAIL lbu got %h want 00000080", MemoryData);
        end
        tick();
        access(1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 32'h80FF0011, 0);
        vec++;
        if (MemoryData !== 32'hFFFF80FF) begin
            miss++;
            $display("FAIL lh_signed got %h want ffff80ff", MemoryData);
        end
        tick();
        access(1'b0, 2'b01, 1'b1, 32'h100, 32'h0, 32'h80FF8011, 2);
        vec++;
        if (MemoryData !== 32'hFFFF8011 || c_stalls !== 4) begin
            miss++;
            $display("FAIL lh_wait md=%h stalls=%0d want ffff8011 4",
                     MemoryData, c_stalls);
        end
        tick();
        access(1'b0, 2'b10, 1'b1, 32'h101, 32'h0, 32'h12345678, 0);
        vec++;
        if (MemoryData !== 32'h00000056) begin
            miss++;
            $display("FAIL lb_pos got %h want 00000056", MemoryData);
        end
        tick();
    endtask

    task automatic test_store();
        access(1'b1, 2'b10, 1'b0, 32'h201, 32'h000000AB, 32'hFFFFFFFF, 0);
        vec++;
        if (c_we !== 1'b1 || c_addr !== 32'h200 || c_be !== 4'b0010 ||
            c_wdata !== 32'hABABABAB) begin
            miss++;
            $display("FAIL sb we=%b addr=%h be=%b wd=%h want 1 200 0010 abababab",
                     c_we, c_addr, c_be, c_wdata);
        end
        vec++;
        if (MemoryData !== 32'h00000056) begin
            miss++;
            $display("FAIL sb_md got %h want 00000056", MemoryData);
        end
        tick();
        access(1'b1, 2'b01, 1'b0, 32'h202, 32'hFFFF1234, 32'h0, 1);
        vec++;
        if (c_be !== 4'b1100 || c_wdata !== 32'h12341234 || c_stalls !== 3) begin
            miss++;
            $display("FAIL sh be=%b wd=%h stalls=%0d want 1100 12341234 3",
                     c_be, c_wdata, c_stalls);
        end
        tick();
        access(1'b1, 2'b11, 1'b0, 32'h204, 32'hCAFEF00D, 32'h0, 0);
        vec++;
        if (c_be !== 4'b1111 || c_wdata !== 32'hCAFEF00D || c_addr !== 32'h204) begin
            miss++;
            $display("FAIL sw be=%b wd=%h addr=%h want 1111 cafef00d 204",
                     c_be, c_wdata, c_addr);
        end
        tick();
    endtask

    task automatic test_misalign();
        EXMEMMemRead   = 1'b1;
        EXMEMMemSize   = 2'b00;
        EXMEMALUResult = 32'h102;
        #1;
        vec++;
        if (MisalignExc !== 1'b1 || MemStall !== 1'b0) begin
            miss++;
            $display("FAIL mis_word exc=%b stall=%b want 1 0", MisalignExc, MemStall);
        end
        tick();
        vec++;
        if (DMemReq !== 1'b0 || MemoryData !== 32'h00000056) begin
            miss++;
            $display("FAIL mis_noreq req=%b md=%h want 0 00000056",
                     DMemReq, MemoryData);
        end
        EXMEMMemRead   = 1'b0;
        EXMEMMemWrite  = 1'b1;
        EXMEMMemSize   = 2'b01;
        EXMEMALUResult = 32'h101;
        #1;
        vec++;
        if (MisalignExc !== 1'b1 || MemStall !== 1'b0) begin
            miss++;
            $display("FAIL mis_half exc=%b stall=%b want 1 0", MisalignExc, MemStall);
        end
        EXMEMMemSize   = 2'b10;
        EXMEMALUResult = 32'h103;
        #1;
        vec++;
        if (MisalignExc !== 1'b0 || MemStall !== 1'b1) begin
            miss++;
            $display("FAIL byte_ok exc=%b stall=%b want 0 1", MisalignExc, MemStall);
        end
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_timeout();
        int n;
        EXMEMMemRead   = 1'b1;
        EXMEMMemSize   = 2'b00;
        EXMEMALUResult = 32'h300;
        tick();
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (DMemReq !== 1'b1) break;
            n++;
            tick();
        end
        EXMEMMemRead = 1'b0;
        vec++;
        if (n !== 16) begin
            miss++;
            $display("FAIL to_cycles got %0d want 16", n);
        end
        vec++;
        if (BusErr !== 1'b1 || MemoryData !== 32'h0 || MemStall !== 1'b0) begin
            miss++;
            $display("FAIL to_done buserr=%b md=%h stall=%b want 1 0 0",
                     BusErr, MemoryData, MemStall);
        end
        tick();
        vec++;
        if (BusErr !== 1'b0) begin
            miss++;
            $display("FAIL to_pulse buserr=%b want 0", BusErr);
        end
        access(1'b0, 2'b00, 1'b0, 32'h300, 32'h0, 32'h13579BDF, 15);
        vec++;
        if (MemoryData !== 32'h13579BDF || BusErr !== 1'b0 || c_stalls !== 17) begin
            miss++;
            $display("FAIL to_ack md=%h buserr=%b stalls=%0d want 13579bdf 0 17",
                     MemoryData, BusErr, c_stalls);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        EXMEMMemRead   = 1'b1;
        EXMEMMemSize   = 2'b00;
        EXMEMALUResult = 32'h400;
        tick();
        tick();
        tick();
        vec++;
        if (DMemReq !== 1'b1 || MemStall !== 1'b1) begin
            miss++;
            $display("FAIL rm_busy req=%b stall=%b want 1 1", DMemReq, MemStall);
        end
        rst          = 1'b1;
        EXMEMMemRead = 1'b0;
        tick();
        rst = 1'b0;
        vec++;
        if (DMemReq !== 1'b0 || MemStall !== 1'b0 || BusErr !== 1'b0) begin
            miss++;
            $display("FAIL rm_abort req=%b stall=%b buserr=%b want 0 0 0",
                     DMemReq, MemStall, BusErr);
        end
        DMemAck   = 1'b1;
        DMemRData = 32'hA5A5A5A5;
        tick();
        DMemAck = 1'b0;
        tick();
        vec++;
        if (MemoryData !== 32'h0 || MemStall !== 1'b0 || DMemReq !== 1'b0) begin
            miss++;
            $display("FAIL rm_late_ack md=%h stall=%b req=%b want 0 0 0",
                     MemoryData, MemStall, DMemReq);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_word_load();
        test_subword_load();
        test_store();
        test_misalign();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
